// File: rtl/alu_serial_ctrl_if.sv
// Issue-side bus for alu_serial_ctrl: start handshake, operands, opcode,
// and the registered result/status returned by the sequencer.
// The ovf signal exists only when ALU_SEQ_OVF_EN is defined.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_SEQ_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, ctl, a, b,
`ifdef ALU_SEQ_OVF_EN
        input  ovf,
`endif
        input  busy, done, result, zero
    );

    modport slave (
        input  start, ctl, a, b,
`ifdef ALU_SEQ_OVF_EN
        output ovf,
`endif
        output busy, done, result, zero
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice LSB-first over
// WIDTH cycles. Carry is threaded through carry_q; SLT is formed from the
// MSB step as sum ^ c_in ^ c_out (overflow-corrected sign).
// Optional: define ALU_SEQ_OVF_EN to add the registered ovf output.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one bit pair per cycle through the slice, bit_cnt 0..WIDTH-1
// DONE  | one cycle; done pulse, result/zero valid
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_serial_ctrl_if.slave      bus,
    output logic                  slice_a,
    output logic                  slice_b,
    output logic                  slice_cin,
    output logic                  slice_inv,
    output logic [2:0]            slice_ctl,
    input  logic                  slice_out,
    input  logic                  slice_cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    bit_cnt;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_next;
    logic             zero_q;
    logic             sum_msb;
    logic             c_in_msb;
    logic             c_out_msb;
    logic             slt_bit;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start)      state_d = ST_RUN;
            ST_RUN:  if (bit_cnt == LAST) state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Accumulator with the current slice bit merged in, and the SLT/MSB terms
    always_comb begin
        acc_next          = acc_q;
        acc_next[bit_cnt] = slice_out;
        sum_msb           = slice_out;
        c_in_msb          = carry_q;
        c_out_msb         = slice_cout;
        slt_bit           = sum_msb ^ c_in_msb ^ c_out_msb;
        result_next       = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : acc_next;
    end

    // Operand latch, bit stepping, carry threading and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            bit_cnt  <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.ctl;
                        bit_cnt <= '0;
                        carry_q <= bus.ctl[2];
                        acc_q   <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= slice_cout;
                    if (bit_cnt == LAST) begin
                        bit_cnt  <= '0;
                        result_q <= result_next;
                        zero_q   <= (result_next == '0);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q;

    // Signed overflow of the MSB step, meaningful only for ADD/SUB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_RUN && bit_cnt == LAST) begin
            ovf_q <= (op_q == OP_ADD || op_q == OP_SUB) ? (c_in_msb ^ c_out_msb) : 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign slice_a   = a_q[bit_cnt];
    assign slice_b   = b_q[bit_cnt];
    assign slice_inv = op_q[2];
    assign slice_cin = carry_q;
    assign slice_ctl = op_q;

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;
    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    logic       slice_a, slice_b, slice_cin, slice_inv;
    logic [2:0] slice_ctl;
    logic       slice_out, slice_cout;
    logic       bb, sum, cy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_inv  (slice_inv),
        .slice_ctl  (slice_ctl),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External slice: AND/OR of a and (optionally inverted) b, or full-add
    always_comb begin
        bb         = slice_b ^ slice_inv;
        sum        = slice_a ^ bb ^ slice_cin;
        cy         = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_ctl)
            3'b000: slice_out = slice_a & bb;
            3'b001: slice_out = slice_a | bb;
            3'b010, 3'b110, 3'b111: begin
                slice_out  = sum;
                slice_cout = cy;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic get_ovf();
`ifdef ALU_SEQ_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // One full operation; returns result/zero/ovf sampled in the done cycle
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ic,
                          output logic [31:0] res, output logic z, output logic ov, output int lat);
        logic busy_bad;
        busy_bad = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.ctl = ic;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.ctl = 3'b001;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        chk("slice_inv_first", {31'd0, slice_inv}, {31'd0, ic[2]});
        chk("slice_cin_first", {31'd0, slice_cin}, {31'd0, ic[2]});
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.busy) busy_bad = 1'b1;
            if (bus.done) break;
        end
        res = bus.result;
        z   = bus.zero;
        ov  = get_ovf();
        chk("busy_held", {31'd0, busy_bad}, 32'd0);
        @(posedge clk); #1;
        chk("done_single", {31'd0, bus.done}, 32'd0);
        chk("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] r;
        logic        z, ov;
        int          lat;
        int          dones;

        vecs[0]  = '{32'd5,         32'd7,         3'b010, 32'd12,        1'b0, 1'b0};
        vecs[1]  = '{32'd3,         32'd5,         3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'd9,         32'd9,         3'b110, 32'd0,         1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'd1,         3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'd1,         3'b111, 32'd1,         1'b0, 1'b0};
        vecs[5]  = '{32'd1,         32'h8000_0000, 3'b111, 32'd0,         1'b1, 1'b0};
        vecs[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0};
        vecs[7]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0};
        vecs[8]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'd0,         1'b1, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'd1,         3'b010, 32'd0,         1'b1, 1'b0};
        vecs[10] = '{32'h7FFF_FFFF, 32'd1,         3'b010, 32'h8000_0000, 1'b0, 1'b1};
        vecs[11] = '{32'd3,         32'd5,         3'b111, 32'd1,         1'b0, 1'b0};
        vecs[12] = '{32'd5,         32'd3,         3'b111, 32'd0,         1'b1, 1'b0};
        vecs[13] = '{32'hFFFF_FFFF, 32'd0,         3'b111, 32'd1,         1'b0, 1'b0};
        vecs[14] = '{32'h1234_5678, 32'h0000_1111, 3'b110, 32'h1234_4567, 1'b0, 1'b0};

        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ctl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero",   {31'd0, bus.zero}, 32'd0);
        chk("rst_ovf",    {31'd0, get_ovf()}, 32'd0);
        chk("rst_slice",  {26'd0, slice_ctl, slice_a, slice_b, slice_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ctl, r, z, ov, lat);
            chk($sformatf("v%0d_result", i), r, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
            chk($sformatf("v%0d_latency", i), lat, 32'd32);
`ifdef ALU_SEQ_OVF_EN
            chk($sformatf("v%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].ov});
`endif
        end

        // start held through RUN with different operands: one op, one done
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.ctl = 3'b010;
        @(posedge clk); #1;
        bus.a = 32'd100; bus.b = 32'd200; bus.ctl = 3'b110;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                chk("held_result", bus.result, 32'd12);
                bus.start = 1'b0;
                @(posedge clk); #1;
                chk("held_done_not_repeat", {31'd0, bus.done}, 32'd0);
            end
        end
        bus.start = 1'b0;
        chk("held_done_count", dones, 32'd1);
        run_op(32'd100, 32'd200, 3'b010, r, z, ov, lat);
        chk("after_held_result", r, 32'd300);

        // reset asserted one cycle while bit 10 of an ADD is in flight
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.ctl = 3'b010;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("midrst_done",   {31'd0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        chk("midrst_zero",   {31'd0, bus.zero}, 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("midrst_no_done", dones, 32'd0);
        run_op(32'd1, 32'd1, 3'b010, r, z, ov, lat);
        chk("post_rst_add", r, 32'd2);
        chk("post_rst_latency", lat, 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
